// File: rtl/csa_final_cpa.sv
// Final carry-propagate adder for the multiplier CSA tree: a two-stage split
// adder that resolves the sum/carry pair into a binary product with valid/ready flow.
module csa_final_cpa #(
    parameter int unsigned W    = 10,
    parameter int unsigned LO_W = 5,
    parameter int unsigned H    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_sum,
    input  logic [W-1:0]          in_carry,
    input  logic [LO_W-1:0]       in_lo,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W+LO_W:0]       out_prod,
    output logic                  out_ovf
);

    localparam int unsigned AW   = W + 2;
    localparam int unsigned HI_W = W + 2 - H;
    localparam int unsigned PW   = W + 1 + LO_W;

    logic              s1_valid_q, s1_valid_d;
    logic [H-1:0]      s1_l_q, s1_l_d;
    logic              s1_c1_q, s1_c1_d;
    logic [HI_W-1:0]   s1_ahi_q, s1_ahi_d;
    logic [HI_W-1:0]   s1_bhi_q, s1_bhi_d;
    logic [LO_W-1:0]   s1_lo_q, s1_lo_d;
    logic              out_valid_q, out_valid_d;
    logic [PW-1:0]     out_prod_q, out_prod_d;
    logic              out_ovf_q, out_ovf_d;

    logic [AW-1:0]     a_ext;
    logic [AW-1:0]     b_ext;
    logic [H:0]        lo_add;
    logic [HI_W-1:0]   u_sum;
    logic              s2_adv;
    logic              accept;

    // s2 can take s1 whenever the output slot is empty or draining this cycle
    assign s2_adv    = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready  = !s1_valid_q || s2_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_prod  = out_prod_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        a_ext  = AW'(in_sum);
        b_ext  = AW'({in_carry, 1'b0});
        lo_add = (H+1)'(a_ext[H-1:0]) + (H+1)'(b_ext[H-1:0]);
        u_sum  = s1_ahi_q + s1_bhi_q + HI_W'(s1_c1_q);
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_l_d      = s1_l_q;
        s1_c1_d     = s1_c1_q;
        s1_ahi_d    = s1_ahi_q;
        s1_bhi_d    = s1_bhi_q;
        s1_lo_d     = s1_lo_q;
        out_valid_d = out_valid_q;
        out_prod_d  = out_prod_q;
        out_ovf_d   = out_ovf_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_l_d     = lo_add[H-1:0];
            s1_c1_d    = lo_add[H];
            s1_ahi_d   = a_ext[AW-1:H];
            s1_bhi_d   = b_ext[AW-1:H];
            s1_lo_d    = in_lo;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        // Upper slice finishes here; its top bit carries weight 2^(W+1)
        if (s2_adv) begin
            out_valid_d = 1'b1;
            out_prod_d  = {u_sum[W-H:0], s1_l_q, s1_lo_q};
            out_ovf_d   = u_sum[HI_W-1];
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_l_q      <= '0;
            s1_c1_q     <= 1'b0;
            s1_ahi_q    <= '0;
            s1_bhi_q    <= '0;
            s1_lo_q     <= '0;
            out_valid_q <= 1'b0;
            out_prod_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_l_q      <= s1_l_d;
            s1_c1_q     <= s1_c1_d;
            s1_ahi_q    <= s1_ahi_d;
            s1_bhi_q    <= s1_bhi_d;
            s1_lo_q     <= s1_lo_d;
            out_valid_q <= out_valid_d;
            out_prod_q  <= out_prod_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule
